// File: rtl/pipe_flow_ctrl_if.sv
// Control bundle between the pipeline datapath and the stall/flush controller.
interface pipe_flow_ctrl_if;
    // Requests into the controller
    logic        hazard_stall_D;
    logic        md_start_E;
    logic        md_is_div_E;
    logic        md_use_D;
    logic        req_M;
    logic        eret_D;
    logic [31:0] epc;

    // Strobes back to the pipeline
    logic        en_FD;
    logic        en_DE;
    logic        en_EM;
    logic        en_MW;
    logic        clr_DE;
    logic        clr_all;
    logic        npc_override;
    logic [31:0] npc_value;
    logic        md_busy;
    logic [3:0]  md_cnt;

    // Datapath side: raises requests, consumes strobes
    modport master (
        output hazard_stall_D, md_start_E, md_is_div_E, md_use_D,
               req_M, eret_D, epc,
        input  en_FD, en_DE, en_EM, en_MW, clr_DE, clr_all,
               npc_override, npc_value, md_busy, md_cnt
    );

    // Controller side
    modport slave (
        input  hazard_stall_D, md_start_E, md_is_div_E, md_use_D,
               req_M, eret_D, epc,
        output en_FD, en_DE, en_EM, en_MW, clr_DE, clr_all,
               npc_override, npc_value, md_busy, md_cnt
    );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// Stall/flush controller for the 5-stage pipeline, including the mult/div
// busy sequencer that holds HI/LO consumers in D until the unit finishes.
module pipe_flow_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180
) (
    input  logic               clk,
    input  logic               reset,
    pipe_flow_ctrl_if.slave    pif
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_go;
    logic             md_stall;
    logic             stall;

    // A new op starts only from IDLE and never in an exception-entry cycle
    assign md_go = pif.md_start_E & ~pif.req_M & (state_q == ST_IDLE);

    // Sequencer state and down-counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: load the cycle count on issue, count down while busy
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (md_go) begin
                    if (pif.md_is_div_E) begin
                        state_d = ST_DIV;
                        cnt_d   = CNT_W'(DIV_CYCLES);
                    end else begin
                        state_d = ST_MULT;
                        cnt_d   = CNT_W'(MULT_CYCLES);
                    end
                end
            end
            ST_MULT, ST_DIV: begin
                // Last busy cycle is cnt==1; <= guards against a stray 0
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Busy status comes straight off the state/counter flops
    assign pif.md_busy = (state_q != ST_IDLE);
    assign pif.md_cnt  = cnt_q;

    // Issue-cycle term covers the gap before md_busy rises
    assign md_stall = pif.md_use_D & (pif.md_busy | pif.md_start_E);
    assign stall    = pif.hazard_stall_D | md_stall;

    // Pipeline strobes and NPC override; exception entry outranks stall and eret
    always_comb begin
        pif.en_FD        = 1'b1;
        pif.en_DE        = 1'b1;
        pif.en_EM        = 1'b1;
        pif.en_MW        = 1'b1;
        pif.clr_DE       = 1'b0;
        pif.clr_all      = 1'b0;
        pif.npc_override = 1'b0;
        pif.npc_value    = 32'h0;
        if (pif.req_M) begin
            pif.clr_all      = 1'b1;
            pif.npc_override = 1'b1;
            pif.npc_value    = EXC_VECTOR;
        end else begin
            pif.en_FD  = ~stall;
            pif.clr_DE = stall;
            // A stalled eret is retried once the stall clears
            if (pif.eret_D && !stall) begin
                pif.npc_override = 1'b1;
                pif.npc_value    = pif.epc;
            end
        end
    end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed bench for pipe_flow_ctrl: stimulus pushes hand-computed
// expectations into a queue, a monitor pops and compares every cycle.
module tb_pipe_flow_ctrl;

    logic clk;
    logic reset;

    pipe_flow_ctrl_if pif ();

    pipe_flow_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .pif   (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {en_FD, en_DE, en_EM, en_MW, clr_DE, clr_all, npc_override, md_busy}
    typedef struct {
        string       name;
        logic [7:0]  flags;
        logic [3:0]  cnt;
        logic [31:0] npc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] EXC_PC = 32'h0000_4180;

    // Normal flow, no redirect
    function automatic exp_t norm(input logic stl, input logic busy, input logic [3:0] cnt);
        exp_t e;
        e.name  = "";
        e.flags = {~stl, 1'b1, 1'b1, 1'b1, stl, 1'b0, 1'b0, busy};
        e.cnt   = cnt;
        e.npc   = 32'h0;
        return e;
    endfunction

    // Exception entry: everything enabled, full flush, vector redirect
    function automatic exp_t exc(input logic busy, input logic [3:0] cnt);
        exp_t e;
        e.name  = "";
        e.flags = {4'b1111, 1'b0, 1'b1, 1'b1, busy};
        e.cnt   = cnt;
        e.npc   = EXC_PC;
        return e;
    endfunction

    // Unstalled eret redirect to EPC
    function automatic exp_t ert(input logic [31:0] pc, input logic busy, input logic [3:0] cnt);
        exp_t e;
        e.name  = "";
        e.flags = {4'b1111, 1'b0, 1'b0, 1'b1, busy};
        e.cnt   = cnt;
        e.npc   = pc;
        return e;
    endfunction

    // Apply one cycle of inputs just after the edge and queue what it should produce
    task automatic step(input string nm, input logic rst, input logic hz, input logic st,
                        input logic dv, input logic use_d, input logic rq, input logic er,
                        input logic [31:0] ep, input exp_t e);
        @(posedge clk);
        #1;
        reset              = rst;
        pif.hazard_stall_D = hz;
        pif.md_start_E     = st;
        pif.md_is_div_E    = dv;
        pif.md_use_D       = use_d;
        pif.req_M          = rq;
        pif.eret_D         = er;
        pif.epc            = ep;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: outputs are settled by the falling edge
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {pif.en_FD, pif.en_DE, pif.en_EM, pif.en_MW, pif.clr_DE,
                       pif.clr_all, pif.npc_override, pif.md_busy};
                checks++;
                if (act !== e.flags || pif.md_cnt !== e.cnt || pif.npc_value !== e.npc) begin
                    errors++;
                    $display("FAIL %s: got flags=%b cnt=%0d npc=%h, expected flags=%b cnt=%0d npc=%h",
                             e.name, act, pif.md_cnt, pif.npc_value, e.flags, e.cnt, e.npc);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        reset              = 1'b1;
        pif.hazard_stall_D = 1'b0;
        pif.md_start_E     = 1'b0;
        pif.md_is_div_E    = 1'b0;
        pif.md_use_D       = 1'b0;
        pif.req_M          = 1'b0;
        pif.eret_D         = 1'b0;
        pif.epc            = 32'h0;
        repeat (2) @(posedge clk);

        //   name            rst hz st dv use rq er epc
        step("reset_state",  1, 0, 0, 0, 0, 0, 0, 32'h0, norm(0, 0, 4'd0));
        step("idle",         0, 0, 0, 0, 0, 0, 0, 32'h0, norm(0, 0, 4'd0));

        // mult issue with mflo waiting in D: held cycles 0..5, released at 6
        step("mult_issue",   0, 0, 1, 0, 1, 0, 0, 32'h0, norm(1, 0, 4'd0));
        for (int i = 5; i >= 1; i--)
            step($sformatf("mult_busy_%0d", i), 0, 0, 0, 0, 1, 0, 0, 32'h0, norm(1, 1, 4'(i)));
        step("mult_done",    0, 0, 0, 0, 1, 0, 0, 32'h0, norm(0, 0, 4'd0));

        // div issue, busy 10 cycles; re-issue while cnt reads 7 is ignored
        step("div_issue",    0, 0, 1, 1, 0, 0, 0, 32'h0, norm(0, 0, 4'd0));
        for (int i = 10; i >= 8; i--)
            step($sformatf("div_busy_%0d", i), 0, 0, 0, 0, 0, 0, 0, 32'h0, norm(0, 1, 4'(i)));
        step("div_restart_ignored", 0, 0, 1, 0, 0, 0, 0, 32'h0, norm(0, 1, 4'd7));
        for (int i = 6; i >= 1; i--)
            step($sformatf("div_busy_%0d", i), 0, 0, 0, 0, 0, 0, 0, 32'h0, norm(0, 1, 4'(i)));
        step("div_done",     0, 0, 0, 0, 0, 0, 0, 32'h0, norm(0, 0, 4'd0));

        // exception beats a data-hazard stall
        step("exc_over_stall", 0, 1, 0, 0, 0, 1, 0, 32'h0, exc(0, 4'd0));
        // exception beats eret and an md stall in the same cycle
        step("exc_over_eret",  0, 0, 1, 0, 1, 1, 1, 32'h0000_3010, exc(0, 4'd0));
        step("exc_blocked_issue", 0, 0, 0, 0, 0, 0, 0, 32'h0, norm(0, 0, 4'd0));

        // eret redirect, then the same eret held by a hazard stall, then retried
        step("eret",          0, 0, 0, 0, 0, 0, 1, 32'h0000_3010, ert(32'h0000_3010, 0, 4'd0));
        step("eret_stalled",  0, 1, 0, 0, 0, 0, 1, 32'h0000_3010, norm(1, 0, 4'd0));
        step("eret_retry",    0, 0, 0, 0, 0, 0, 1, 32'h0000_3010, ert(32'h0000_3010, 0, 4'd0));

        // reset in the middle of a div clears the unit and releases D
        step("div2_issue",   0, 0, 1, 1, 0, 0, 0, 32'h0, norm(0, 0, 4'd0));
        for (int i = 10; i >= 8; i--)
            step($sformatf("div2_busy_%0d", i), 0, 0, 0, 0, 1, 0, 0, 32'h0, norm(1, 1, 4'(i)));
        step("div2_reset",   1, 0, 0, 0, 1, 0, 0, 32'h0, norm(1, 1, 4'd7));
        step("after_reset",  0, 0, 0, 0, 1, 0, 0, 32'h0, norm(0, 0, 4'd0));
        step("after_reset_idle", 0, 0, 0, 0, 0, 0, 0, 32'h0, norm(0, 0, 4'd0));

        // drain the scoreboard within a bounded number of cycles
        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
